// File: rtl/layer0_input_packer_if.sv
// Sample-in / packed-vector-out bundle between the readout stream and the layer-0 neuron LUTs.
// master = the packer itself, slave = whatever feeds samples and drains vectors.
interface layer0_input_packer_if #(
  parameter int SAMPLE_W = 16,
  parameter int Q_BITS   = 2,
  parameter int N_FEAT   = 32,
  parameter int CNT_W    = 32
);
  logic                       s_valid;
  logic                       s_ready;
  logic [SAMPLE_W-1:0]        s_data;
  logic                       s_last;
  logic                       m_valid;
  logic                       m_ready;
  logic [N_FEAT*Q_BITS-1:0]   m_data;
  logic                       m_short;
  logic [CNT_W-1:0]           frame_cnt;

  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_short, frame_cnt
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_short, frame_cnt
  );
endinterface

// File: rtl/layer0_input_packer.sv
// Quantizes signed samples to Q_BITS codes and packs N_FEAT per vector; closing sample to m_valid is 1 cycle.
// A second completed frame parks in the accumulator under backpressure and s_ready drops until it moves out.
module layer0_input_packer #(
  parameter int SAMPLE_W = 16,
  parameter int Q_BITS   = 2,
  parameter int N_FEAT   = 32,
  parameter int SHIFT    = 8,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  layer0_input_packer_if.master bus
);
  localparam int VEC_W = N_FEAT * Q_BITS;
  localparam int IDX_W = $clog2(N_FEAT);
  localparam logic signed [SAMPLE_W:0] BIAS     = (SAMPLE_W+1)'(1 << (Q_BITS-1));
  localparam logic signed [SAMPLE_W:0] CODE_MAX = (SAMPLE_W+1)'((1 << Q_BITS) - 1);
  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N_FEAT - 1);

  typedef enum logic {FILL, HOLD} state_e;

  state_e                     state_q;
  logic                       s_ready_q;
  logic                       m_valid_q;
  logic                       m_short_q;
  logic                       held_short_q;
  logic [IDX_W-1:0]           idx_q;
  logic [VEC_W-1:0]           acc_q;
  logic [VEC_W-1:0]           m_data_q;
  logic [CNT_W-1:0]           cnt_q;

  logic signed [SAMPLE_W-1:0] shifted;
  logic signed [SAMPLE_W:0]   biased;
  logic [Q_BITS-1:0]          code;
  logic [VEC_W-1:0]           acc_d;
  logic                       short_d;
  logic                       accept;
  logic                       close;
  logic                       drain;
  logic                       out_free;

  // One extra bit of headroom so the bias can never wrap a large positive sample negative.
  always_comb begin
    shifted = $signed(bus.s_data) >>> SHIFT;
    biased  = {shifted[SAMPLE_W-1], shifted} + BIAS;
    if (biased < 0) begin
      code = '0;
    end else if (biased > CODE_MAX) begin
      code = '1;
    end else begin
      code = biased[Q_BITS-1:0];
    end
  end

  always_comb begin
    acc_d = acc_q;
    acc_d[int'(idx_q)*Q_BITS +: Q_BITS] = code;
  end

  assign accept   = bus.s_valid & s_ready_q;
  assign close    = accept & (bus.s_last | (idx_q == LAST_IDX));
  assign short_d  = (idx_q != LAST_IDX);
  assign drain    = m_valid_q & bus.m_ready;
  assign out_free = ~m_valid_q | bus.m_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= FILL;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_short_q    <= 1'b0;
      held_short_q <= 1'b0;
      idx_q        <= '0;
      acc_q        <= '0;
      m_data_q     <= '0;
      cnt_q        <= '0;
    end else begin
      if (drain) begin
        cnt_q     <= cnt_q + CNT_W'(1);
        m_valid_q <= 1'b0;
      end
      case (state_q)
        FILL: begin
          s_ready_q <= 1'b1;
          if (close) begin
            if (out_free) begin
              m_data_q  <= acc_d;
              m_short_q <= short_d;
              m_valid_q <= 1'b1;
              acc_q     <= '0;
              idx_q     <= '0;
            end else begin
              acc_q        <= acc_d;
              held_short_q <= short_d;
              s_ready_q    <= 1'b0;
              state_q      <= HOLD;
            end
          end else if (accept) begin
            acc_q <= acc_d;
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        HOLD: begin
          if (drain) begin
            m_data_q  <= acc_q;
            m_short_q <= held_short_q;
            m_valid_q <= 1'b1;
            acc_q     <= '0;
            idx_q     <= '0;
            s_ready_q <= 1'b1;
            state_q   <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_short   = m_short_q;
  assign bus.frame_cnt = cnt_q;
endmodule

// File: tb/tb_layer0_input_packer.sv
// Bench for the layer-0 input packer: directed vectors, corner sequences and a random stream against a frame-level model.
module tb_layer0_input_packer;
  localparam int SW = 16;
  localparam int QB = 2;
  localparam int NF = 4;
  localparam int SH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer0_input_packer_if #(.SAMPLE_W(SW), .Q_BITS(QB), .N_FEAT(NF), .CNT_W(32)) bus ();
  layer0_input_packer_if #(.SAMPLE_W(SW), .Q_BITS(QB), .N_FEAT(NF), .CNT_W(2))  bus2 ();

  layer0_input_packer #(.SAMPLE_W(SW), .Q_BITS(QB), .N_FEAT(NF), .SHIFT(SH), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  layer0_input_packer #(.SAMPLE_W(SW), .Q_BITS(QB), .N_FEAT(NF), .SHIFT(SH), .CNT_W(2)) u_dut_wrap (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int failures = 0;
  int stalls = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Code = clamp(floor(sample / 2^SHIFT) + 2, 0, 3), using integer floor division.
  function automatic int qcode(logic [15:0] s);
    int si, t, v;
    si = int'($signed(s));
    t  = (si >= 0) ? si / 256 : -((-si + 255) / 256);
    v  = t + 2;
    return (v < 0) ? 0 : (v > 3) ? 3 : v;
  endfunction

  // Frame-level reference: codes of the open frame, and completed {short,data} awaiting output.
  int         part[$];
  logic [8:0] expq[$];
  int         hs_cnt = 0;
  bit         lat_pend = 0;
  logic [8:0] lat_exp;
  bit         stab_pend = 0;
  logic [8:0] stab_val;

  always @(negedge clk) begin
    if (!rst_n) begin
      part.delete();
      expq.delete();
      hs_cnt    = 0;
      lat_pend  = 0;
      stab_pend = 0;
    end else begin
      if (lat_pend) begin
        chk("latency_vld", bus.m_valid, 1);
        chk("latency_dat", {bus.m_short, bus.m_data}, lat_exp);
        lat_pend = 0;
      end
      if (stab_pend) begin
        chk("stall_stable", {bus.m_valid, bus.m_short, bus.m_data}, {1'b1, stab_val});
        stab_pend = 0;
      end
      chk("frame_cnt", bus.frame_cnt, 64'(hs_cnt));
      if (bus.m_valid && bus.m_ready) begin
        if (expq.size() == 0) begin
          chk("spurious_vec", {bus.m_short, bus.m_data}, 64'h1_0000);
        end else begin
          chk("scoreboard", {bus.m_short, bus.m_data}, expq.pop_front());
        end
        hs_cnt++;
      end else if (bus.m_valid) begin
        stab_pend = 1;
        stab_val  = {bus.m_short, bus.m_data};
      end
      if (bus.s_valid && bus.s_ready) begin
        part.push_back(qcode(bus.s_data));
        if (bus.s_last || part.size() == NF) begin
          int d;
          logic [8:0] f;
          d = 0;
          for (int i = 0; i < part.size(); i++) d += part[i] * (1 << (2 * i));
          f = {(part.size() < NF), 8'(d)};
          expq.push_back(f);
          if (!bus.m_valid || bus.m_ready) begin
            lat_pend = 1;
            lat_exp  = f;
          end
          part.delete();
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    tick();
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_m_short", bus.m_short, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send(logic [15:0] d, logic last);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    @(negedge clk);
    while (!bus.s_ready && n < 50) begin
      n++;
      stalls++;
      @(negedge clk);
    end
    chk("send_ready", bus.s_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mvalid();
    int n;
    n = 0;
    while (!bus.m_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("m_valid_wait", bus.m_valid, 1);
  endtask

  typedef struct packed {
    logic [3:0][15:0] smp;
    logic [2:0]       n;
    logic             last;
    logic [7:0]       dat;
    logic             shrt;
  } vec_t;

  function automatic vec_t mk(logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d,
                              int n, logic last, logic [7:0] dat, logic shrt);
    vec_t v;
    v.smp  = {d, c, b, a};
    v.n    = 3'(n);
    v.last = last;
    v.dat  = dat;
    v.shrt = shrt;
    return v;
  endfunction

  vec_t tbl[6];

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = mk(16'h0100, 16'h0000, 16'h0000, 16'h0000, 2, 1'b1, 8'h0B, 1'b1);
    tbl[1] = mk(16'h0200, 16'h01FF, 16'hFE00, 16'hFDFF, 4, 1'b0, 8'h0F, 1'b0);
    tbl[2] = mk(16'h00FF, 16'h0000, 16'h0000, 16'h0000, 1, 1'b1, 8'h02, 1'b1);
    tbl[3] = mk(16'hFFFF, 16'hFEFF, 16'h0080, 16'h0000, 3, 1'b1, 8'h21, 1'b1);
    tbl[4] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4, 1'b1, 8'hFF, 1'b0);
    tbl[5] = mk(16'h0101, 16'hFF80, 16'h0000, 16'h80FF, 4, 1'b0, 8'h27, 1'b0);

    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
    bus2.s_valid = 1'b0; bus2.s_data = '0; bus2.s_last = 1'b0; bus2.m_ready = 1'b1;
    do_reset();

    // Quantize/pack with first-vector latency.
    send(16'h0000, 1'b0);
    send(16'hFF00, 1'b0);
    send(16'h7FFF, 1'b0);
    bus.s_valid = 1'b1; bus.s_data = 16'h8000; bus.s_last = 1'b0;
    @(negedge clk);
    chk("pre_close_vld", bus.m_valid, 0);
    chk("pre_close_rdy", bus.s_ready, 1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    chk("qp_vld", bus.m_valid, 1);
    chk("qp_dat", bus.m_data, 8'h36);
    chk("qp_short", bus.m_short, 0);
    tick();
    chk("qp_cnt", bus.frame_cnt, 1);
    chk("qp_vld_drop", bus.m_valid, 0);

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < int'(tbl[i].n); k++)
        send(tbl[i].smp[k], (k == int'(tbl[i].n) - 1) && tbl[i].last);
      bus.s_valid = 1'b0;
      wait_mvalid();
      chk("tbl_dat", bus.m_data, tbl[i].dat);
      chk("tbl_short", bus.m_short, tbl[i].shrt);
      tick();
    end

    // Backpressure: one frame in the output register, one parked.
    do_reset();
    bus.m_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(16'h0000, 1'b0);
    bus.s_valid = 1'b0;
    chk("bp_hold_rdy", bus.s_ready, 0);
    chk("bp_vld", bus.m_valid, 1);
    chk("bp_dat1", bus.m_data, 8'hAA);
    tick();
    tick();
    chk("bp_dat1_stable", bus.m_data, 8'hAA);
    chk("bp_still_hold", bus.s_ready, 0);
    bus.m_ready = 1'b1;
    tick();
    chk("bp_vld_cont", bus.m_valid, 1);
    chk("bp_dat2", bus.m_data, 8'hAA);
    chk("bp_rdy_back", bus.s_ready, 1);
    chk("bp_cnt1", bus.frame_cnt, 1);
    tick();
    chk("bp_vld_drop", bus.m_valid, 0);
    chk("bp_cnt2", bus.frame_cnt, 2);

    // Full-rate streaming.
    do_reset();
    bus.m_ready = 1'b1;
    stalls = 0;
    for (int k = 0; k < 12; k++) send(16'($urandom), 1'b0);
    bus.s_valid = 1'b0;
    chk("stream_stalls", 64'(stalls), 0);
    tick();
    tick();
    chk("stream_cnt", bus.frame_cnt, 3);

    // Reset in the middle of a frame.
    do_reset();
    send(16'h0000, 1'b0);
    send(16'h0000, 1'b0);
    bus.s_valid = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) send(16'h7FFF, 1'b0);
    bus.s_valid = 1'b0;
    wait_mvalid();
    chk("rm_dat", bus.m_data, 8'hFF);
    chk("rm_short", bus.m_short, 0);
    tick();
    chk("rm_cnt", bus.frame_cnt, 1);

    // Random stream against the model.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bus.s_valid = ($urandom_range(9) < 7);
      bus.s_data  = 16'($urandom);
      bus.s_last  = ($urandom_range(5) == 0);
      bus.m_ready = ($urandom_range(9) < 6);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (10) tick();
    chk("rand_drained", 64'(expq.size()), 0);

    // Counter wrap on the narrow-counter instance.
    for (int k = 0; k < 5; k++) begin
      bus2.s_valid = 1'b1; bus2.s_last = 1'b1; bus2.s_data = 16'h0100;
      n = 0;
      @(negedge clk);
      while (!bus2.s_ready && n < 20) begin
        n++;
        @(negedge clk);
      end
      chk("wrap_ready", bus2.s_ready, 1);
      @(posedge clk); #1;
      bus2.s_valid = 1'b0;
      chk("wrap_vld", bus2.m_valid, 1);
      chk("wrap_dat", {bus2.m_short, bus2.m_data}, 9'h103);
      tick();
      chk("wrap_cnt", bus2.frame_cnt, 64'((k + 1) % 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/layer0_input_packer.md
Name: layer0_input_packer

Overview:
- Front end of the layer-0 neuron array.
- Takes a stream of signed readout samples and quantizes each one to a Q_BITS-wide code.
- Packs N_FEAT consecutive codes into the flat input vector that the layer-0 neuron LUTs slice their inputs from.
- Presents each completed vector on a valid/ready output with single-frame buffering. This is the producer side of the packed-code interface the neuron LUTs consume.

Parameters:
- SAMPLE_W, 16, signed input sample width.
- Q_BITS, 2, bits per quantized code.
- N_FEAT, 32, codes per output vector (≥2).
- SHIFT, 8, arithmetic right-shift applied before biasing (0 ≤ SHIFT < SAMPLE_W).
- CNT_W, 32, width of frame counter.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  synchronous active-low reset.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- s_data  in  SAMPLE_W  signed two's-complement sample.
- s_last  in  1  marks final sample of a frame (may close frame early).
- m_valid  out  1  packed vector valid.
- m_ready  in  1  downstream accept.
- m_data  out  N_FEAT*Q_BITS  packed codes; feature i at bits [i*Q_BITS +: Q_BITS], feature 0 in LSBs.
- m_short  out  1  vector was closed by s_last before N_FEAT samples; the tail is zero-filled.
- frame_cnt  out  CNT_W  number of vectors accepted downstream (m_valid & m_ready), wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low at a clock edge):
  - Outputs: m_valid=0, m_data=0, m_short=0, frame_cnt=0, s_ready=0 during the reset cycle.
  - Internal: accumulator cleared, feature index=0, state=FILL.
  - Reset mid-frame discards partial and buffered frames; no output is produced for them.
- Quantize (combinational on s_data):
  - t = s_data >>> SHIFT (arithmetic).
  - v = t + 2^(Q_BITS-1), computed at SAMPLE_W+1 bits.
  - code = 0 if v<0; 2^Q_BITS-1 if v>2^Q_BITS-1; else v[Q_BITS-1:0].
- State FILL:
  - s_ready=1.
  - On accept: the code is written to slot idx, and idx increments.
  - Close the frame when idx==N_FEAT-1, or when s_last=1 at any idx.
  - On close: the accumulator (including the current code) and short=(idx<N_FEAT-1) form the completed frame.
  - Unwritten slots of a short frame are 0.
- Frame close:
  - If the output register is empty, or is being drained this same cycle (m_valid & m_ready), load m_data/m_short next edge and set m_valid=1. Latency: the closing sample's accept edge to m_valid high is 1 cycle.
  - Clear the accumulator and set idx=0; stay in FILL. Back-to-back frames run at full rate.
  - Otherwise go to HOLD, with the completed frame held in the accumulator.
- State HOLD:
  - s_ready=0.
  - When m_ready & m_valid: load the held frame into the output register (m_valid stays 1), clear the accumulator, set idx=0, go to FILL.
  - s_ready returns high the cycle after the transfer.
- Output register:
  - m_data/m_short are stable while m_valid & !m_ready.
  - m_valid drops after the handshake if no new frame is loaded on that same edge.
- frame_cnt increments on each m_valid & m_ready; it wraps from 2^CNT_W-1 to 0.
- s_last on sample N_FEAT-1 is a normal full frame, m_short=0.
- An s_last-less stream is packed in consecutive groups of N_FEAT.
- s_data/s_last are ignored when s_valid=0 or s_ready=0.
- There are no combinational paths from m_ready to s_ready; s_ready is a registered function of state.

Test Plan (N_FEAT=4, Q_BITS=2, SHIFT=8, SAMPLE_W=16):
- Quantize/pack: samples 0x0000, 0xFF00 (−256), 0x7FFF, 0x8000 with m_ready=1 -> codes 2,1,3,0; m_data=8'h36, m_short=0, m_valid high exactly 1 cycle after 4th accept; frame_cnt=1.
- Short frame: samples 0x0100, 0x0000 with s_last on 2nd -> m_data=8'h0B (slot0=3, slot1=2, rest 0), m_short=1; the next frame starts at slot 0.
- Backpressure: m_ready=0, send 8 samples of 0x0000 -> frame1 m_data=8'hAA held stable; after 4 more samples s_ready=0 (HOLD); raise m_ready -> frame1 accepted, frame2 8'hAA appears with m_valid continuous, s_ready high the following cycle; frame_cnt=2 after both.
- Full-rate streaming: 12 continuous samples, m_ready=1 -> s_ready never drops; 3 vectors, each 1 cycle after its closing sample.
- Reset mid-operation: accept 2 samples, pull rst_n low 1 cycle, then send 4 samples of 0x7FFF -> single vector 8'hFF, m_short=0, frame_cnt=1; no vector from the discarded samples.
- Counter wrap (CNT_W=2): 5 handshaken frames -> frame_cnt sequence 1,2,3,0,1.
